// File: rtl/rs_alu_unit_if.sv
// Dispatch, CDB snoop and CDB broadcast signals of the MOV/ADD/JEQ reservation station.
// master = dispatcher/CDB side, slave = the station itself.
interface rs_alu_unit_if #(
  parameter int TAG_W = 15
);
  logic             disp_v;
  logic [3:0]       disp_op;
  logic             disp_a_busy;
  logic [TAG_W-1:0] disp_a_src;
  logic [15:0]      disp_a_val;
  logic             disp_b_busy;
  logic [TAG_W-1:0] disp_b_src;
  logic [15:0]      disp_b_val;
  logic             full;
  logic [TAG_W-1:0] free_tag;
  logic             cdb_in_v;
  logic [TAG_W-1:0] cdb_in_tag;
  logic [15:0]      cdb_in_val;
  logic             cdb_req;
  logic             cdb_gnt;
  logic [TAG_W-1:0] cdb_out_tag;
  logic [3:0]       cdb_out_op;
  logic [15:0]      cdb_out_val;

  modport master (
    output disp_v, disp_op, disp_a_busy, disp_a_src, disp_a_val,
           disp_b_busy, disp_b_src, disp_b_val,
           cdb_in_v, cdb_in_tag, cdb_in_val, cdb_gnt,
    input  full, free_tag, cdb_req, cdb_out_tag, cdb_out_op, cdb_out_val
  );

  modport slave (
    input  disp_v, disp_op, disp_a_busy, disp_a_src, disp_a_val,
           disp_b_busy, disp_b_src, disp_b_val,
           cdb_in_v, cdb_in_tag, cdb_in_val, cdb_gnt,
    output full, free_tag, cdb_req, cdb_out_tag, cdb_out_op, cdb_out_val
  );
endinterface

// File: rtl/rs_alu_unit.sv
// Reservation station + single ALU: captures operands from the CDB, issues the lowest ready
// entry into an issue register, then a result register that holds until the CDB grant.
module rs_alu_unit #(
  parameter int NUM_RS   = 4,
  parameter int TAG_W    = 15,
  parameter int BASE_TAG = 1
) (
  input logic          clk,
  input logic          rst_n,
  rs_alu_unit_if.slave io_bus
);

  localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_JEQ = 4'h3;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2,
    ST_EXEC  = 2'd3
  } st_e;

  typedef struct packed {
    logic [3:0]       op;
    logic             a_busy;
    logic [TAG_W-1:0] a_src;
    logic [15:0]      a_val;
    logic             b_busy;
    logic [TAG_W-1:0] b_src;
    logic [15:0]      b_val;
  } ent_t;

  st_e               r_st     [NUM_RS];
  st_e               w_st_nxt [NUM_RS];
  ent_t              r_ent    [NUM_RS];
  ent_t              w_new;

  logic [NUM_RS-1:0] w_snp_a;
  logic [NUM_RS-1:0] w_snp_b;
  logic              w_free_found;
  logic [IDX_W-1:0]  w_free_idx;
  logic              w_rdy_found;
  logic [IDX_W-1:0]  w_rdy_idx;
  logic              w_disp_acc;
  logic              w_a_hit;
  logic              w_b_hit;
  logic              w_grant;
  logic              w_alu_adv;
  logic              w_issue;

  logic              r_alu_v;
  logic [IDX_W-1:0]  r_alu_idx;
  logic [3:0]        r_alu_op;
  logic [15:0]       r_alu_a;
  logic [15:0]       r_alu_b;
  logic [15:0]       w_alu_val;

  logic              r_res_v;
  logic [IDX_W-1:0]  r_res_idx;
  logic [TAG_W-1:0]  r_res_tag;
  logic [3:0]        r_res_op;
  logic [15:0]       r_res_val;

  // An issue slot opens when the issue register is empty or drains into the result register.
  assign w_grant    = r_res_v && io_bus.cdb_gnt;
  assign w_alu_adv  = r_alu_v && (!r_res_v || w_grant);
  assign w_issue    = w_rdy_found && (!r_alu_v || w_alu_adv);
  assign w_disp_acc = io_bus.disp_v && w_free_found;

  // New entry image; a same-cycle CDB broadcast of a pending producer is taken directly.
  always_comb begin
    w_a_hit      = io_bus.disp_a_busy && io_bus.cdb_in_v && (io_bus.cdb_in_tag == io_bus.disp_a_src);
    w_b_hit      = io_bus.disp_b_busy && io_bus.cdb_in_v && (io_bus.cdb_in_tag == io_bus.disp_b_src);
    w_new        = '0;
    w_new.op     = io_bus.disp_op;
    w_new.a_busy = io_bus.disp_a_busy && !w_a_hit;
    w_new.a_src  = io_bus.disp_a_src;
    w_new.a_val  = w_a_hit ? io_bus.cdb_in_val : io_bus.disp_a_val;
    w_new.b_busy = (io_bus.disp_op != OP_MOV) && io_bus.disp_b_busy && !w_b_hit;
    w_new.b_src  = io_bus.disp_b_src;
    w_new.b_val  = w_b_hit ? io_bus.cdb_in_val : io_bus.disp_b_val;
  end

  always_comb begin
    w_snp_a = '0;
    w_snp_b = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      w_snp_a[i] = (r_st[i] == ST_WAIT) && r_ent[i].a_busy && io_bus.cdb_in_v &&
                   (io_bus.cdb_in_tag == r_ent[i].a_src);
      w_snp_b[i] = (r_st[i] == ST_WAIT) && r_ent[i].b_busy && io_bus.cdb_in_v &&
                   (io_bus.cdb_in_tag == r_ent[i].b_src);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RS; i++) r_st[i] <= ST_FREE;
    end else begin
      for (int i = 0; i < NUM_RS; i++) r_st[i] <= w_st_nxt[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RS; i++) begin
      w_st_nxt[i] = r_st[i];
      case (r_st[i])
        ST_FREE: begin
          if (w_disp_acc && (w_free_idx == IDX_W'(i)))
            w_st_nxt[i] = (w_new.a_busy || w_new.b_busy) ? ST_WAIT : ST_READY;
        end
        ST_WAIT: begin
          if ((!r_ent[i].a_busy || w_snp_a[i]) && (!r_ent[i].b_busy || w_snp_b[i]))
            w_st_nxt[i] = ST_READY;
        end
        ST_READY: begin
          if (w_issue && (w_rdy_idx == IDX_W'(i)))
            w_st_nxt[i] = ST_EXEC;
        end
        ST_EXEC: begin
          if (w_grant && (r_res_idx == IDX_W'(i)))
            w_st_nxt[i] = ST_FREE;
        end
        default: w_st_nxt[i] = ST_FREE;
      endcase
    end
  end

  // Descending scan so the lowest matching index wins.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_rdy_found  = 1'b0;
    w_rdy_idx    = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (r_st[i] == ST_FREE) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
      if (r_st[i] == ST_READY) begin
        w_rdy_found = 1'b1;
        w_rdy_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RS; i++) r_ent[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_RS; i++) begin
        if (w_disp_acc && (w_free_idx == IDX_W'(i))) begin
          r_ent[i] <= w_new;
        end else begin
          if (w_snp_a[i]) begin
            r_ent[i].a_busy <= 1'b0;
            r_ent[i].a_val  <= io_bus.cdb_in_val;
          end
          if (w_snp_b[i]) begin
            r_ent[i].b_busy <= 1'b0;
            r_ent[i].b_val  <= io_bus.cdb_in_val;
          end
        end
      end
    end
  end

  always_comb begin
    w_alu_val = '0;
    case (r_alu_op)
      OP_MOV:  w_alu_val = r_alu_a;
      OP_ADD:  w_alu_val = r_alu_a + r_alu_b;
      OP_JEQ:  w_alu_val = {15'd0, (r_alu_a == r_alu_b)};
      default: w_alu_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_v   <= 1'b0;
      r_alu_idx <= '0;
      r_alu_op  <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_res_v   <= 1'b0;
      r_res_idx <= '0;
      r_res_tag <= '0;
      r_res_op  <= '0;
      r_res_val <= '0;
    end else begin
      if (w_issue) begin
        r_alu_v   <= 1'b1;
        r_alu_idx <= w_rdy_idx;
        r_alu_op  <= r_ent[w_rdy_idx].op;
        r_alu_a   <= r_ent[w_rdy_idx].a_val;
        r_alu_b   <= r_ent[w_rdy_idx].b_val;
      end else if (w_alu_adv) begin
        r_alu_v <= 1'b0;
      end
      // Result fields only change on load, so they stay stable while waiting for a grant.
      if (w_alu_adv) begin
        r_res_v   <= 1'b1;
        r_res_idx <= r_alu_idx;
        r_res_tag <= TAG_W'(BASE_TAG) + TAG_W'(r_alu_idx);
        r_res_op  <= r_alu_op;
        r_res_val <= w_alu_val;
      end else if (w_grant) begin
        r_res_v <= 1'b0;
      end
    end
  end

  assign io_bus.full        = !w_free_found;
  assign io_bus.free_tag    = TAG_W'(BASE_TAG) + TAG_W'(w_free_idx);
  assign io_bus.cdb_req     = r_res_v;
  assign io_bus.cdb_out_tag = r_res_tag;
  assign io_bus.cdb_out_op  = r_res_op;
  assign io_bus.cdb_out_val = r_res_val;

endmodule

// File: tb/tb_rs_alu_unit.sv
// Bench for rs_alu_unit: expected CDB results are queued at dispatch and compared on broadcast.
module tb_rs_alu_unit;
  localparam int TAG_W = 15;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_JEQ = 4'h3;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [3:0]       op;
    logic [15:0]      val;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  res_t sb_q[$];
  res_t obs_q[$];
  int   obs_cyc[$];
  logic             tb_cdb_v;
  logic [TAG_W-1:0] tb_cdb_tag;
  logic [15:0]      tb_cdb_val;

  rs_alu_unit_if #(.TAG_W(TAG_W)) bus ();

  rs_alu_unit #(.NUM_RS(4), .TAG_W(TAG_W), .BASE_TAG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  // Global CDB: external broadcasts, otherwise the unit's own granted result.
  always_comb begin
    if (tb_cdb_v) begin
      bus.cdb_in_v   = 1'b1;
      bus.cdb_in_tag = tb_cdb_tag;
      bus.cdb_in_val = tb_cdb_val;
    end else begin
      bus.cdb_in_v   = bus.cdb_req && bus.cdb_gnt;
      bus.cdb_in_tag = bus.cdb_out_tag;
      bus.cdb_in_val = bus.cdb_out_val;
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog timeout reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  function automatic res_t mk(input logic [TAG_W-1:0] t, input logic [3:0] o, input logic [15:0] v);
    res_t r;
    r.tag = t;
    r.op  = o;
    r.val = v;
    return r;
  endfunction

  function automatic res_t cur_out();
    res_t r;
    r.tag = bus.cdb_out_tag;
    r.op  = bus.cdb_out_op;
    r.val = bus.cdb_out_val;
    return r;
  endfunction

  task automatic dispatch(input logic [3:0] op, input logic ab, input logic [TAG_W-1:0] as,
                          input logic [15:0] av, input logic bb, input logic [TAG_W-1:0] bs,
                          input logic [15:0] bv);
    bus.disp_v      = 1'b1;
    bus.disp_op     = op;
    bus.disp_a_busy = ab;
    bus.disp_a_src  = as;
    bus.disp_a_val  = av;
    bus.disp_b_busy = bb;
    bus.disp_b_src  = bs;
    bus.disp_b_val  = bv;
    @(negedge clk);
    bus.disp_v = 1'b0;
  endtask

  task automatic broadcast(input logic [TAG_W-1:0] t, input logic [15:0] v);
    tb_cdb_v   = 1'b1;
    tb_cdb_tag = t;
    tb_cdb_val = v;
    @(negedge clk);
    tb_cdb_v = 1'b0;
  endtask

  // Holds grant high and records each result that is granted, up to n or the cycle budget.
  task automatic collect(input int n, input int budget);
    obs_q.delete();
    obs_cyc.delete();
    bus.cdb_gnt = 1'b1;
    for (int k = 0; k < budget; k++) begin
      if (bus.cdb_req) begin
        obs_q.push_back(cur_out());
        obs_cyc.push_back(k);
      end
      @(negedge clk);
      if (obs_q.size() >= n) break;
    end
    bus.cdb_gnt = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.disp_v = 1'b0; bus.disp_op = '0;
    bus.disp_a_busy = 1'b0; bus.disp_a_src = '0; bus.disp_a_val = '0;
    bus.disp_b_busy = 1'b0; bus.disp_b_src = '0; bus.disp_b_val = '0;
    bus.cdb_gnt = 1'b0;
    tb_cdb_v = 1'b0; tb_cdb_tag = '0; tb_cdb_val = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%0b exp=0", bus.full); end
    n_checks++; if (bus.free_tag !== 15'd1) begin n_fail++; $display("FAIL reset_free_tag got=%0d exp=1", bus.free_tag); end
    n_checks++; if (bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%0b exp=0", bus.cdb_req); end
    n_checks++; if (cur_out() !== mk(15'd0, 4'h0, 16'h0)) begin n_fail++; $display("FAIL reset_out got=%h exp=0", cur_out()); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_add();
    res_t exp;
    n_checks++; if (bus.free_tag !== 15'd1) begin n_fail++; $display("FAIL add_pre_tag got=%0d exp=1", bus.free_tag); end
    sb_q.push_back(mk(15'd1, OP_ADD, 16'd7));
    dispatch(OP_ADD, 1'b0, 15'd0, 16'd3, 1'b0, 15'd0, 16'd4);
    n_checks++; if (bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL add_lat1 got=%0b exp=0", bus.cdb_req); end
    @(negedge clk);
    n_checks++; if (bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL add_lat2 got=%0b exp=0", bus.cdb_req); end
    @(negedge clk);
    n_checks++; if (bus.cdb_req !== 1'b1) begin n_fail++; $display("FAIL add_req got=%0b exp=1", bus.cdb_req); end
    n_checks++; if (bus.free_tag !== 15'd2) begin n_fail++; $display("FAIL add_busy_tag got=%0d exp=2", bus.free_tag); end
    exp = sb_q.pop_front();
    n_checks++; if (cur_out() !== exp) begin n_fail++; $display("FAIL add_result got=%h exp=%h", cur_out(), exp); end
    @(negedge clk);
    n_checks++; if (bus.cdb_req !== 1'b1 || cur_out() !== exp) begin n_fail++; $display("FAIL add_hold got req=%0b out=%h exp req=1 out=%h", bus.cdb_req, cur_out(), exp); end
    bus.cdb_gnt = 1'b1;
    @(negedge clk);
    bus.cdb_gnt = 1'b0;
    n_checks++; if (bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL add_granted got=%0b exp=0", bus.cdb_req); end
    n_checks++; if (bus.free_tag !== 15'd1) begin n_fail++; $display("FAIL add_freed got=%0d exp=1", bus.free_tag); end
  endtask

  task automatic test_wait_wrap();
    res_t exp;
    sb_q.push_back(mk(15'd1, OP_ADD, 16'd3));
    dispatch(OP_ADD, 1'b1, 15'd9, 16'd0, 1'b0, 15'd0, 16'd5);
    @(negedge clk);
    broadcast(15'd9, 16'hFFFE);
    n_checks++; if (bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL wrap_waited got=%0b exp=0", bus.cdb_req); end
    @(negedge clk);
    n_checks++; if (bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL wrap_lat got=%0b exp=0", bus.cdb_req); end
    @(negedge clk);
    n_checks++; if (bus.cdb_req !== 1'b1) begin n_fail++; $display("FAIL wrap_req got=%0b exp=1", bus.cdb_req); end
    collect(1, 10);
    exp = sb_q.pop_front();
    n_checks++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL wrap_count got=%0d exp=1", obs_q.size()); end
    else begin
      n_checks++; if (obs_q[0] !== exp) begin n_fail++; $display("FAIL wrap_result got=%h exp=%h", obs_q[0], exp); end
    end
  endtask

  task automatic test_bypass();
    res_t exp;
    sb_q.push_back(mk(15'd1, OP_ADD, 16'd12));
    tb_cdb_v = 1'b1; tb_cdb_tag = 15'd9; tb_cdb_val = 16'd10;
    dispatch(OP_ADD, 1'b1, 15'd9, 16'd0, 1'b0, 15'd0, 16'd2);
    tb_cdb_v = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL byp_lat got=%0b exp=0", bus.cdb_req); end
    @(negedge clk);
    n_checks++; if (bus.cdb_req !== 1'b1) begin n_fail++; $display("FAIL byp_req got=%0b exp=1", bus.cdb_req); end
    collect(1, 10);
    exp = sb_q.pop_front();
    n_checks++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL byp_count got=%0d exp=1", obs_q.size()); end
    else begin
      n_checks++; if (obs_q[0] !== exp) begin n_fail++; $display("FAIL byp_result got=%h exp=%h", obs_q[0], exp); end
    end
  endtask

  task automatic test_back_to_back();
    res_t exp;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.free_tag !== TAG_W'(i + 1)) begin n_fail++; $display("FAIL fill_tag%0d got=%0d exp=%0d", i, bus.free_tag, i + 1); end
      dispatch(OP_ADD, 1'b1, 15'd20, 16'd0, 1'b0, 15'd0, 16'(i * 16));
      sb_q.push_back(mk(TAG_W'(i + 1), OP_ADD, 16'(1 + i * 16)));
    end
    n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL fill_full got=%0b exp=1", bus.full); end
    dispatch(OP_ADD, 1'b0, 15'd0, 16'h0055, 1'b0, 15'd0, 16'h0001);
    repeat (2) @(negedge clk);
    n_checks++; if (bus.full !== 1'b1 || bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL fill_ignored got full=%0b req=%0b exp full=1 req=0", bus.full, bus.cdb_req); end
    broadcast(15'd20, 16'd1);
    collect(4, 20);
    n_checks++; if (obs_q.size() !== 4) begin n_fail++; $display("FAIL drain_count got=%0d exp=4", obs_q.size()); end
    for (int i = 0; i < 4; i++) begin
      exp = sb_q.pop_front();
      if (i < obs_q.size()) begin
        n_checks++; if (obs_q[i] !== exp) begin n_fail++; $display("FAIL drain_result%0d got=%h exp=%h", i, obs_q[i], exp); end
        if (i > 0) begin
          n_checks++; if (obs_cyc[i] - obs_cyc[i-1] !== 1) begin n_fail++; $display("FAIL drain_gap%0d got=%0d exp=1", i, obs_cyc[i] - obs_cyc[i-1]); end
        end
      end
    end
    repeat (3) @(negedge clk);
    n_checks++; if (bus.cdb_req !== 1'b0 || bus.full !== 1'b0 || bus.free_tag !== 15'd1) begin n_fail++; $display("FAIL drain_idle got req=%0b full=%0b tag=%0d exp 0 0 1", bus.cdb_req, bus.full, bus.free_tag); end
  endtask

  task automatic test_jeq_chain();
    res_t exp;
    sb_q.push_back(mk(15'd1, OP_JEQ, 16'd1));
    sb_q.push_back(mk(15'd2, OP_JEQ, 16'd0));
    sb_q.push_back(mk(15'd3, OP_ADD, 16'd101));
    dispatch(OP_JEQ, 1'b0, 15'd0, 16'd5, 1'b0, 15'd0, 16'd5);
    dispatch(OP_JEQ, 1'b0, 15'd0, 16'd5, 1'b0, 15'd0, 16'd6);
    dispatch(OP_ADD, 1'b1, 15'd1, 16'd0, 1'b0, 15'd0, 16'd100);
    collect(3, 20);
    n_checks++; if (obs_q.size() !== 3) begin n_fail++; $display("FAIL jeq_count got=%0d exp=3", obs_q.size()); end
    for (int i = 0; i < 3; i++) begin
      exp = sb_q.pop_front();
      if (i < obs_q.size()) begin
        n_checks++; if (obs_q[i] !== exp) begin n_fail++; $display("FAIL jeq_result%0d got=%h exp=%h", i, obs_q[i], exp); end
      end
    end
  endtask

  task automatic test_unknown_op();
    res_t exp;
    sb_q.push_back(mk(15'd1, 4'hF, 16'd0));
    dispatch(4'hF, 1'b0, 15'd0, 16'd3, 1'b0, 15'd0, 16'd4);
    collect(1, 10);
    exp = sb_q.pop_front();
    n_checks++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL unk_count got=%0d exp=1", obs_q.size()); end
    else begin
      n_checks++; if (obs_q[0] !== exp) begin n_fail++; $display("FAIL unk_result got=%h exp=%h", obs_q[0], exp); end
    end
  endtask

  task automatic test_stall_reset();
    res_t exp;
    sb_q.push_back(mk(15'd1, OP_MOV, 16'h1234));
    dispatch(OP_MOV, 1'b0, 15'd0, 16'h1234, 1'b1, 15'd7, 16'd0);
    dispatch(OP_MOV, 1'b0, 15'd0, 16'h5678, 1'b0, 15'd0, 16'd0);
    @(negedge clk);
    exp = sb_q.pop_front();
    n_checks++; if (bus.cdb_req !== 1'b1 || cur_out() !== exp) begin n_fail++; $display("FAIL stall_first got req=%0b out=%h exp req=1 out=%h", bus.cdb_req, cur_out(), exp); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (bus.cdb_req !== 1'b1 || cur_out() !== exp) begin n_fail++; $display("FAIL stall_hold%0d got req=%0b out=%h exp req=1 out=%h", c, bus.cdb_req, cur_out(), exp); end
    end
    n_checks++; if (bus.free_tag !== 15'd3 || bus.full !== 1'b0) begin n_fail++; $display("FAIL stall_tag got tag=%0d full=%0b exp 3 0", bus.free_tag, bus.full); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.cdb_req !== 1'b0 || bus.full !== 1'b0 || bus.free_tag !== 15'd1) begin n_fail++; $display("FAIL rst_mid got req=%0b full=%0b tag=%0d exp 0 0 1", bus.cdb_req, bus.full, bus.free_tag); end
    n_checks++; if (cur_out() !== mk(15'd0, 4'h0, 16'h0)) begin n_fail++; $display("FAIL rst_mid_out got=%h exp=0", cur_out()); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL rst_flushed got=%0b exp=0", bus.cdb_req); end
    sb_q.push_back(mk(15'd1, OP_ADD, 16'h0000));
    dispatch(OP_ADD, 1'b0, 15'd0, 16'hFFFF, 1'b0, 15'd0, 16'h0001);
    collect(1, 10);
    exp = sb_q.pop_front();
    n_checks++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL post_rst_count got=%0d exp=1", obs_q.size()); end
    else begin
      n_checks++; if (obs_q[0] !== exp) begin n_fail++; $display("FAIL post_rst_result got=%h exp=%h", obs_q[0], exp); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_wait_wrap();
    test_bypass();
    test_back_to_back();
    test_jeq_chain();
    test_unknown_op();
    test_stall_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_alu_unit.md
Name: rs_alu_unit

Overview:
- Reservation station plus single ALU for the Tomasulo core.
- Sits downstream of the dispatcher and is the responder end of the dispatch interface. It accepts MOV/ADD/JEQ operations with register-file operand snapshots (busy/src/val), captures missing operands from the CDB, and executes the oldest-index ready entry.
- Broadcasts results back on the CDB through a request/grant handshake.

Parameters:
- NUM_RS, 4, number of station entries (1..8)
- TAG_W, 15, tag width; matches the register-file src field
- BASE_TAG, 1, tag of entry 0; entry i owns tag BASE_TAG+i (tag 0 reserved for "none")

Ports:
- clk  in  1  core clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- disp_v  in  1  dispatch strobe, one op per cycle
- disp_op  in  4  opcode (`MOV, `ADD, `JEQ)
- disp_a_busy  in  1  operand A pending
- disp_a_src  in  TAG_W  producer tag for A
- disp_a_val  in  16  A value (or immediate for MOV)
- disp_b_busy  in  1  operand B pending
- disp_b_src  in  TAG_W  producer tag for B
- disp_b_val  in  16  B value
- full  out  1  no free entry
- free_tag  out  TAG_W  tag the next accepted dispatch receives; dispatcher writes {1,free_tag} into rt
- cdb_in_v  in  1  CDB broadcast valid (global bus, includes own results)
- cdb_in_tag  in  TAG_W  broadcasting tag
- cdb_in_val  in  16  broadcast value
- cdb_req  out  1  result waiting for bus
- cdb_gnt  in  1  arbiter grant for this unit
- cdb_out_tag  out  TAG_W  result tag
- cdb_out_op  out  4  opcode of result (dispatcher detects JEQ resolution)
- cdb_out_val  out  16  result value

Behaviour:
- Reset (async, rst_n=0): all entries FREE, result register empty; full=0, free_tag=BASE_TAG, cdb_req=0, cdb_out_*=0. Reset mid-operation discards all entries and pending results.
- Entry states: FREE -> WAIT (operand pending) or READY (both present) on dispatch; WAIT -> READY when last pending tag is seen on the CDB; READY -> EXEC on issue; EXEC -> FREE on the cycle cdb_gnt is sampled high.
- A tag is never reused before its result has been broadcast.
- free_tag: lowest-index FREE entry. full=1 when no entry is FREE.
- Dispatch while full is ignored and no state changes.
- Dispatch/CDB bypass: if disp_a_busy and cdb_in_v and cdb_in_tag==disp_a_src in the same cycle, capture cdb_in_val and mark A present. Same rule for B.
- Snoop: every WAIT entry compares both pending src tags to cdb_in_tag each cycle while cdb_in_v=1. Both operands may be captured from the same broadcast.
- Operand B is treated as present for MOV regardless of disp_b_busy.
- Issue: lowest-index READY entry moves to the ALU when the result register is empty or is being granted this cycle. Back-to-back issue is allowed. At most one issue per cycle.
- ALU (result registered 1 cycle after issue):
  - MOV: val = A.
  - ADD: val = (A+B) mod 2^16; carry dropped.
  - JEQ: val = 16'h0001 if A==B, else 16'h0000.
- CDB output: cdb_req=1 while the result register is full. cdb_out_* are stable while cdb_req=1 and cdb_gnt=0.
- On grant, the entry frees at that edge. That tag is eligible as free_tag in the next cycle.
- Earliest broadcast: a fully ready op dispatched at edge N issues at N+1 and has cdb_req=1 after N+2.
- Simultaneous events:
  - Dispatch into the entry freed by this cycle's grant: not allowed; free_tag reflects pre-edge state.
  - A dispatched op whose producer is being granted in the same cycle captures the value via bypass.
  - Own broadcast wakes dependent entries like any other CDB value.
- Unknown opcodes are accepted and produce val=0.

Test Plan:
- Reset then dispatch ADD A=3 B=4 (both ready) -> free_tag=1 before dispatch; cdb_req high 2 cycles later with tag 1, op `ADD, val 7; held until gnt; entry freed next cycle.
- ADD A busy src=9, B=5, then cdb_in tag 9 val 16'hFFFE two cycles later -> issue next cycle, result val 3 (wrap), tag 1.
- Dispatch with A src=9 in the same cycle cdb_in tag 9 val 10, B=2 -> bypass captured, result 12, with no extra wait cycle.
- Fill 4 entries all waiting on tag 20 -> full=1, 5th dispatch ignored; broadcast tag 20 val 1 -> results drain in index order tags 1,2,3,4 with gnt held high, one per cycle.
- JEQ A=5 B=5, then JEQ A=5 B=6 -> cdb_out_op `JEQ, vals 1 then 0; chain ADD depending on tag 1 wakes from own broadcast.
- Hold cdb_gnt=0 for 5 cycles with two ready entries -> outputs stable, second not issued past result register; assert rst_n low mid-stall -> cdb_req=0, full=0, free_tag=1 immediately.
